// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: states and constants shared by the PLL reset sequencer.
package pll_reset_pkg;
   typedef enum logic [1:0] {
      HOLD      = 2'd0,
      STABILISE = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;
   localparam logic [7:0] LOCK_CNT_MAX = 8'hFF;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single-bit asynchronous input, cleared by reset.
module sync_2ff (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   logic meta_q, sync_q;
   always_ff @(posedge clock) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end
   assign q_o = sync_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: turns PLL lock into staged synchronous resets, with
// lock filtering, instant re-assertion on loss and a saturating loss counter.
module pll_reset_sequencer
   import pll_reset_pkg::*;
#(
   parameter int LOCK_STABLE_CYCLES = 16,
   parameter int STAGE_GAP          = 8,
   parameter int NSTAGES            = 3,
   parameter int CNT_W              = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               pll_locked,
   input  logic               sw_reset,
   output logic [NSTAGES-1:0] rst_stage,
   output logic               ready,
   output logic [7:0]         lock_loss_count
);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NSTAGES-1:0] rst_q, rst_d, rst_next;
   logic               ready_q, ready_d, locked_s, lock_prev_q;
   logic [7:0]         llc_q;
   sync_2ff u_sync (.clock(clock), .reset(reset), .d_i(pll_locked), .q_o(locked_s));
   // Asserted stages always form a contiguous run at the top, so a left shift releases the next one
   assign rst_next = rst_q << 1;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      rst_d   = rst_q;
      ready_d = ready_q;
      if (sw_reset || (!locked_s && state_q != HOLD)) begin
         state_d = HOLD;
         cnt_d   = '0;
         rst_d   = '1;
         ready_d = 1'b0;
      end else begin
         case (state_q)
            HOLD: begin
               cnt_d   = '0;
               state_d = locked_s ? STABILISE : HOLD;
            end
            STABILISE, RELEASE: begin
               if (cnt_q == ((state_q == STABILISE) ? LOCK_LAST : GAP_LAST)) begin
                  cnt_d   = '0;
                  rst_d   = rst_next;
                  ready_d = ~|rst_next;
                  state_d = (~|rst_next) ? RUN : RELEASE;
               end
            end
            default: cnt_d = '0;
         endcase
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= HOLD;
         cnt_q       <= '0;
         rst_q       <= '1;
         ready_q     <= 1'b0;
         lock_prev_q <= 1'b0;
         llc_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rst_q       <= rst_d;
         ready_q     <= ready_d;
         lock_prev_q <= locked_s;
         if (lock_prev_q && !locked_s && llc_q != LOCK_CNT_MAX) llc_q <= llc_q + 1'b1;
      end
   end
   assign rst_stage       = rst_q;
   assign ready           = ready_q;
   assign lock_loss_count = llc_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed vector table, hand sequences and a randomized
// run against a release-time reference model.
module tb_pll_reset_sequencer;
   localparam int LSC = 16, GAP = 8, N = 3;
   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic       reset = 1'b1, pll_locked = 1'b0, sw_reset = 1'b0;
   logic [2:0] rst_stage;
   logic       ready;
   logic [7:0] llc;
   logic       reset2 = 1'b1, pl2 = 1'b0, sw2 = 1'b0;
   logic       rst2, ready2;
   logic [7:0] llc2;
   int checks = 0, errors = 0;
   pll_reset_sequencer #(.LOCK_STABLE_CYCLES(LSC), .STAGE_GAP(GAP), .NSTAGES(N), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .pll_locked(pll_locked), .sw_reset(sw_reset),
      .rst_stage(rst_stage), .ready(ready), .lock_loss_count(llc));
   pll_reset_sequencer #(.LOCK_STABLE_CYCLES(1), .STAGE_GAP(8), .NSTAGES(1), .CNT_W(16)) dut2 (
      .clock(clock), .reset(reset2), .pll_locked(pl2), .sw_reset(sw2),
      .rst_stage(rst2), .ready(ready2), .lock_loss_count(llc2));
   // Model: h[1] is the synchronised lock, h[2] its previous value; age counts
   // edges since the sequence left HOLD, and stage i is released at age 1+LSC+i*GAP.
   logic [2:0] h = '0;
   int age = 0, mllc = 0;
   always @(posedge clock) begin
      if (reset) begin
         h    <= '0;
         age  <= 0;
         mllc <= 0;
      end else begin
         if (h[2] && !h[1] && mllc < 255) mllc <= mllc + 1;
         age <= (sw_reset || !h[1]) ? 0 : (age < 100000 ? age + 1 : age);
         h   <= {h[1:0], pll_locked};
      end
   end
   function automatic logic [2:0] m_rst(int a);
      logic [2:0] r;
      for (int i = 0; i < N; i++) r[i] = (a < 1 + LSC + i * GAP);
      return r;
   endfunction
   typedef struct {
      logic rs, pl, sw;
      int n;
      logic [2:0] er;
      logic erd;
      logic [7:0] ellc;
   } vec_t;
   vec_t tbl[$];
   task automatic add(logic rs, logic pl, logic sw, int n, logic [2:0] er, logic erd, logic [7:0] ellc);
      vec_t v;
      v.rs = rs; v.pl = pl; v.sw = sw; v.n = n; v.er = er; v.erd = erd; v.ellc = ellc;
      tbl.push_back(v);
   endtask
   task automatic tick(int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask
   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   initial begin
      // power-up: rise sampled at T, releases at T+18/26/34
      add(1, 0, 0, 4, 3'b111, 0, 0);
      add(0, 1, 0, 17, 3'b111, 0, 0);
      add(0, 1, 0, 1, 3'b111, 0, 0);
      add(0, 1, 0, 1, 3'b110, 0, 0);
      add(0, 1, 0, 7, 3'b110, 0, 0);
      add(0, 1, 0, 1, 3'b100, 0, 0);
      add(0, 1, 0, 7, 3'b100, 0, 0);
      add(0, 1, 0, 1, 3'b000, 1, 0);
      add(0, 1, 0, 5, 3'b000, 1, 0);
      // sw_reset in RUN: assert next edge, stage 0 back 17 edges later
      add(0, 1, 1, 1, 3'b111, 0, 0);
      add(0, 1, 0, 16, 3'b111, 0, 0);
      add(0, 1, 0, 1, 3'b110, 0, 0);
      // glitch in STABILISE restarts the window
      add(1, 0, 0, 3, 3'b111, 0, 0);
      add(0, 1, 0, 10, 3'b111, 0, 0);
      add(0, 0, 0, 1, 3'b111, 0, 0);
      add(0, 1, 0, 2, 3'b111, 0, 1);
      add(0, 1, 0, 16, 3'b111, 0, 1);
      add(0, 1, 0, 1, 3'b110, 0, 1);
      // lock loss in RELEASE, then relock and full re-run
      add(0, 1, 0, 3, 3'b110, 0, 1);
      add(0, 0, 0, 1, 3'b110, 0, 1);
      add(0, 1, 0, 1, 3'b110, 0, 1);
      add(0, 1, 0, 1, 3'b111, 0, 2);
      add(0, 1, 0, 16, 3'b111, 0, 2);
      add(0, 1, 0, 1, 3'b110, 0, 2);
      add(0, 1, 0, 16, 3'b000, 1, 2);
      foreach (tbl[k]) begin
         reset = tbl[k].rs; pll_locked = tbl[k].pl; sw_reset = tbl[k].sw;
         tick(tbl[k].n);
         chk($sformatf("vec%0d_rst", k), {5'd0, rst_stage}, {5'd0, tbl[k].er});
         chk($sformatf("vec%0d_ready", k), {7'd0, ready}, {7'd0, tbl[k].erd});
         chk($sformatf("vec%0d_llc", k), llc, tbl[k].ellc);
      end
      // saturation
      reset = 1; pll_locked = 0; sw_reset = 0;
      tick(2);
      reset = 0;
      for (int i = 0; i < 100; i++) begin
         pll_locked = 1; tick(1);
         pll_locked = 0; tick(1);
      end
      tick(4);
      chk("sat_llc_100", llc, 8'd100);
      for (int i = 0; i < 200; i++) begin
         pll_locked = 1; tick(1);
         pll_locked = 0; tick(1);
      end
      tick(4);
      chk("sat_llc_255", llc, 8'd255);
      reset = 1; tick(1);
      chk("sat_reset_llc", llc, 8'd0);
      chk("sat_reset_rst", {5'd0, rst_stage}, 8'h07);
      chk("sat_reset_ready", {7'd0, ready}, 8'd0);
      // single stage, single stable cycle
      reset2 = 1; pl2 = 0; tick(2);
      reset2 = 0; pl2 = 1; tick(3);
      chk("n1_before_rst", {7'd0, rst2}, 8'd1);
      tick(1);
      chk("n1_rel_rst", {7'd0, rst2}, 8'd0);
      chk("n1_rel_ready", {7'd0, ready2}, 8'd1);
      reset2 = 1; sw2 = 1; tick(1);
      chk("n1_rstsw_rst", {7'd0, rst2}, 8'd1);
      chk("n1_rstsw_ready", {7'd0, ready2}, 8'd0);
      chk("n1_rstsw_llc", llc2, 8'd0);
      reset2 = 0; sw2 = 0; tick(3);
      chk("n1_rerun_hold", {7'd0, rst2}, 8'd1);
      tick(1);
      chk("n1_rerun_rst", {7'd0, rst2}, 8'd0);
      chk("n1_rerun_ready", {7'd0, ready2}, 8'd1);
      // randomized run against the model
      reset = 1; sw_reset = 0; pll_locked = 0; tick(2);
      reset = 0;
      for (int c = 0; c < 5000; c++) begin
         pll_locked = ($urandom_range(89) == 0) ? ~pll_locked : pll_locked;
         sw_reset = ($urandom_range(299) == 0);
         reset = ($urandom_range(1999) == 0);
         tick(1);
         chk("rnd_rst", {5'd0, rst_stage}, {5'd0, m_rst(age)});
         chk("rnd_ready", {7'd0, ready}, {7'd0, age >= 1 + LSC + (N - 1) * GAP});
         chk("rnd_llc", llc, mllc[7:0]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the board PLL. Consumes the PLL's asynchronous `locked` output and produces staged, synchronous, active-high resets for the consumers in this clock domain: timers/audio first, then video, then GPU/CPU.
- Filters lock glitches and requires lock to hold for a programmable number of cycles before release.
- Re-asserts every reset immediately when lock is lost.
- Reports readiness and keeps a saturating count of lock losses for debug.

Parameters:
- LOCK_STABLE_CYCLES, 16: consecutive synchronised-lock cycles required before stage 0 releases; legal range ≥ 1.
- STAGE_GAP, 8: cycles between successive stage releases; legal range ≥ 1.
- NSTAGES, 3: number of reset outputs, released in ascending index order; legal range 1..8.
- CNT_W, 16: width of the internal cycle counter; must hold max(LOCK_STABLE_CYCLES, STAGE_GAP).

Ports:
- clock, in, 1: sole clock.
- reset, in, 1: synchronous, active-high; board/button reset.
- pll_locked, in, 1: PLL lock flag, asynchronous to clock.
- sw_reset, in, 1: synchronous single-cycle request to re-run the sequence.
- rst_stage, out, NSTAGES: per-stage reset, active-high, registered.
- ready, out, 1: high when all stages are released.
- lock_loss_count, out, 8: saturating count of lock losses.

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values: rst_stage = all ones, ready = 0, lock_loss_count = 0, state = HOLD, counter = 0, both synchroniser flops = 0.
- Synchroniser: pll_locked passes through a 2-flop synchroniser to give locked_s. A pll_locked rise sampled at edge T is visible as locked_s = 1 at edge T+1, and the FSM acts on it at edge T+2. Falls have the same latency.
- FSM states:
  - HOLD: all rst_stage = 1, ready = 0. When locked_s = 1, go to STABILISE with cnt = 0.
  - STABILISE: while locked_s = 1, cnt increments each cycle. When cnt == LOCK_STABLE_CYCLES-1, go to RELEASE with stage index idx = 0, clear rst_stage[0] on that same edge, and set cnt = 0.
  - RELEASE: cnt increments each cycle. When cnt == STAGE_GAP-1, clear rst_stage[idx+1], increment idx, and set cnt = 0. On the edge that clears rst_stage[NSTAGES-1], go to RUN.
  - RUN: ready = 1, registered on the edge that enters RUN, i.e. the same edge that clears the last stage. Stays in RUN until lock is lost, sw_reset, or reset.
- Lock loss: locked_s = 0 in STABILISE, RELEASE or RUN sends the FSM to HOLD on the next edge. That edge sets all rst_stage = 1 and ready = 0 together, with no staging on assertion. A partially released sequence is abandoned, and cnt and idx clear.
- lock_loss_count:
  - Increments on every locked_s 1→0 transition, in any state.
  - Saturates at 255.
  - Cleared only by reset.
- sw_reset:
  - Acts like a lock loss (go to HOLD, all resets asserted) but does not increment lock_loss_count.
  - If locked_s = 1, HOLD exits to STABILISE on the following edge, so the full stabilise window is re-run.
  - sw_reset in HOLD holds HOLD for that cycle.
- Priority when events coincide: reset > sw_reset > lock loss > counting.
- NSTAGES = 1: RELEASE is entered and exited on the same edge, so RUN is entered directly from STABILISE.
- Output rules:
  - rst_stage bits, once cleared, never re-assert individually; they re-assert only all together.
  - ready = 1 exactly when rst_stage == 0.
- All outputs come straight from flops; no combinational path from any input to any output.

Decomposition:
- Shared package pll_reset_pkg holds:
  - the state enum (HOLD, STABILISE, RELEASE, RUN) as 2-bit constants;
  - LOCK_CNT_MAX = 8'hFF.
- One sub-module, sync_2ff: a 2-flop synchroniser with synchronous clear on reset. It is reused by other clock-domain crossings in the codebase.

Test Plan:
All scenarios use default parameters unless stated; T is the edge at which the pll_locked rise is first sampled.
1. Normal power-up. Hold reset for 4 cycles, then raise pll_locked at edge T → rst_stage[0] falls at T+18, rst_stage[1] at T+26, rst_stage[2] at T+34; ready rises at T+34.
2. Lock glitch during STABILISE. pll_locked high for 10 cycles, low for 1, then high → no stage releases; lock_loss_count = 1; the 16-cycle window restarts.
3. Lock loss during RELEASE. Drop pll_locked 3 cycles after rst_stage[0] falls → all rst_stage = 3'b111 two edges after the next sampled fall, with no staging on re-assertion; ready stays 0; lock_loss_count increments by 1; the sequence re-runs after relock.
4. sw_reset pulse in RUN with lock held → all resets assert on the next edge; lock_loss_count unchanged; stage 0 releases 17 edges after the pulse (1 edge in HOLD, then the 16-cycle window).
5. Saturation. Toggle pll_locked 300 times → lock_loss_count = 255. Assert reset → count = 0, rst_stage = 3'b111, ready = 0.
6. Parameter corners. With NSTAGES=1, LOCK_STABLE_CYCLES=1 and a lock rise sampled at T → rst_stage[0] and ready change at T+3. Assert reset and sw_reset together → reset values, with no extra HOLD cycle.
